// File: rtl/rbi_mmu_acl_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module : rbi_mmu_pkg
// Brief  : Shared ACL entry layout, FSM encodings and helpers for the ACL cache.
// Rev    : 1.0 - initial release
// ============================================================================
package rbi_mmu_pkg;

    localparam int ACL_ENTRY_W = 48;
    localparam int ACLID_LSB   = 0;
    localparam int ACLID_MSB   = 15;
    localparam int KEY_LSB     = 16;
    localparam int KEY_MSB     = 31;
    localparam int MODE_LSB    = 32;
    localparam int MODE_MSB    = 43;

    typedef logic [ACL_ENTRY_W-1:0] acl_entry_t;

    typedef enum logic [1:0] {
        ACL_IDLE  = 2'd0,
        ACL_MREQ  = 2'd1,
        ACL_MWAIT = 2'd2
    } acl_state_t;

    // Index of the lowest set bit; 0 when none is set (callers qualify with |v).
    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        lowest_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) lowest_idx = 2'(i);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/rbi_mmu_acl_cache_if.sv
`default_nettype none
// ============================================================================
// Module : rbi_mmu_acl_cache_if
// Brief  : Pipeline, load, miss-handshake and entry-output bundle of the ACL cache.
// Rev    : 1.0 - initial release
// ============================================================================
interface rbi_mmu_acl_cache_if;
    import rbi_mmu_pkg::*;

    logic        regInHold;
    logic [63:0] regInKRR;
    logic        lookInValid;
    logic [15:0] lookInAclId;
    logic        aclInLdValid;
    acl_entry_t  aclInLdEntry;
    logic        aclOutLdAck;
    logic        aclInFlush;
    logic        aclOutMissReq;
    logic [15:0] aclOutMissId;
    logic        aclInMissAck;
    logic        aclOutMissFail;
    logic        regOutHoldMiss;
    acl_entry_t  aclEntryA;
    acl_entry_t  aclEntryB;
    acl_entry_t  aclEntryC;
    acl_entry_t  aclEntryD;

    modport master (
        output regInHold, regInKRR, lookInValid, lookInAclId,
               aclInLdValid, aclInLdEntry, aclInFlush, aclInMissAck,
        input  aclOutLdAck, aclOutMissReq, aclOutMissId, aclOutMissFail,
               regOutHoldMiss, aclEntryA, aclEntryB, aclEntryC, aclEntryD
    );

    modport slave (
        input  regInHold, regInKRR, lookInValid, lookInAclId,
               aclInLdValid, aclInLdEntry, aclInFlush, aclInMissAck,
        output aclOutLdAck, aclOutMissReq, aclOutMissId, aclOutMissFail,
               regOutHoldMiss, aclEntryA, aclEntryB, aclEntryC, aclEntryD
    );

endinterface
`default_nettype wire

// File: rtl/rbi_mmu_acl_cache_match.sv
`default_nettype none
// ============================================================================
// Module : rbi_mmu_acl_match
// Brief  : Per-slot compare: entry valid, lookup hit against KRR, load duplicate.
// Rev    : 1.0 - initial release
// ============================================================================
module rbi_mmu_acl_match
    import rbi_mmu_pkg::*;
(
    input  acl_entry_t  entry,
    input  logic [15:0] look_id,
    input  logic [63:0] krr,
    input  acl_entry_t  ld_entry,
    output logic        valid,
    output logic        hit,
    output logic        ld_dup
);

    logic key_ok;
    logic unused_bits;

    // Zero keys in the keyring are empty slots and never grant access.
    always_comb begin
        key_ok = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if ((krr[16*k +: 16] != 16'h0) && (krr[16*k +: 16] == entry[KEY_MSB:KEY_LSB]))
                key_ok = 1'b1;
        end
    end

    assign valid  = (entry[MODE_LSB +: 3] != 3'b000);
    assign hit    = (entry[ACLID_MSB:ACLID_LSB] == look_id) && key_ok;
    assign ld_dup = (entry[ACLID_MSB:ACLID_LSB] == ld_entry[ACLID_MSB:ACLID_LSB]) &&
                    (entry[KEY_MSB:KEY_LSB] == ld_entry[KEY_MSB:KEY_LSB]);

    assign unused_bits = ^{entry[ACL_ENTRY_W-1:MODE_LSB+3], ld_entry[ACL_ENTRY_W-1:KEY_MSB+1]};

endmodule
`default_nettype wire

// File: rtl/rbi_mmu_acl_cache.sv
`default_nettype none
// ============================================================================
// Module : rbi_mmu_acl_cache
// Brief  : Four-entry ACL cache with miss handshake; RBI_ACL_MTF_EN selects
//          move-to-front, otherwise round-robin load replacement.
// Rev    : 1.0 - initial release
// ============================================================================
module rbi_mmu_acl_cache
    import rbi_mmu_pkg::*;
#(
    parameter int MISS_TMO = 255
) (
    input  logic                clock,
    input  logic                reset,
    rbi_mmu_acl_cache_if.slave  bus
);

    localparam logic [7:0] TMO_LAST = 8'(MISS_TMO - 1);

    acl_entry_t  ent     [4];
    acl_entry_t  ent_nxt [4];
    acl_state_t  state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [15:0] miss_id, miss_id_nxt;
    logic        fail, fail_nxt;

    logic [3:0]  vld, hit_raw, dup_raw, hit_v, dup_v;
    logic        hit_any, dup_any;
    logic [1:0]  dup_idx;
    logic        look_ok, miss_det, load_go;

    for (genvar i = 0; i < 4; i++) begin : g_match
        rbi_mmu_acl_match u_match (
            .entry    (ent[i]),
            .look_id  (bus.lookInAclId),
            .krr      (bus.regInKRR),
            .ld_entry (bus.aclInLdEntry),
            .valid    (vld[i]),
            .hit      (hit_raw[i]),
            .ld_dup   (dup_raw[i])
        );
    end

    assign hit_v    = hit_raw & vld;
    assign dup_v    = dup_raw & vld;
    assign hit_any  = |hit_v;
    assign dup_any  = |dup_v;
    assign dup_idx  = lowest_idx(dup_v);

    assign look_ok  = bus.lookInValid && !bus.regInHold && (state == ACL_IDLE);
    assign miss_det = look_ok && !hit_any && !bus.aclInFlush;
    // Flush wins over a load: the load is left pending for the next cycle.
    assign load_go  = bus.aclInLdValid && !bus.aclInFlush;

`ifdef RBI_ACL_MTF_EN
    logic [1:0] hit_idx;
    logic       promote;
    logic [1:0] mtf_pos;
    acl_entry_t mtf_val;
    logic       mtf_do;

    assign hit_idx = lowest_idx(hit_v);
    assign promote = look_ok && hit_any && (hit_idx != 2'd0) && !load_go && !bus.aclInFlush;

    always_comb begin
        mtf_do  = 1'b0;
        mtf_pos = 2'd3;
        mtf_val = bus.aclInLdEntry;
        if (load_go) begin
            mtf_do  = 1'b1;
            mtf_pos = dup_any ? dup_idx : 2'd3;
        end else if (promote) begin
            mtf_do  = 1'b1;
            mtf_pos = hit_idx;
            mtf_val = ent[hit_idx];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) ent_nxt[i] = ent[i];
        if (bus.aclInFlush) begin
            for (int i = 0; i < 4; i++) ent_nxt[i] = '0;
        end else if (mtf_do) begin
            for (int i = 1; i < 4; i++) begin
                if (i <= int'(mtf_pos)) ent_nxt[i] = ent[i-1];
            end
            ent_nxt[0] = mtf_val;
        end
    end
`else
    logic [1:0] rr, rr_nxt;

    always_comb begin
        for (int i = 0; i < 4; i++) ent_nxt[i] = ent[i];
        rr_nxt = rr;
        if (bus.aclInFlush) begin
            for (int i = 0; i < 4; i++) ent_nxt[i] = '0;
        end else if (load_go) begin
            if (dup_any) begin
                ent_nxt[dup_idx] = bus.aclInLdEntry;
            end else begin
                ent_nxt[rr] = bus.aclInLdEntry;
                rr_nxt      = rr + 2'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rr <= 2'd0;
        else       rr <= rr_nxt;
    end
`endif

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        miss_id_nxt = miss_id;
        fail_nxt    = 1'b0;
        if (bus.aclInFlush) begin
            state_nxt = ACL_IDLE;
            cnt_nxt   = 8'd0;
        end else begin
            case (state)
                ACL_IDLE: begin
                    if (miss_det) begin
                        state_nxt   = ACL_MREQ;
                        miss_id_nxt = bus.lookInAclId;
                    end
                end
                ACL_MREQ: begin
                    if (bus.aclInMissAck) begin
                        state_nxt = ACL_MWAIT;
                        cnt_nxt   = 8'd0;
                    end
                end
                ACL_MWAIT: begin
                    cnt_nxt = cnt + 8'd1;
                    if (load_go && (bus.aclInLdEntry[ACLID_MSB:ACLID_LSB] == miss_id)) begin
                        state_nxt = ACL_IDLE;
                    end else if (cnt == TMO_LAST) begin
                        state_nxt = ACL_IDLE;
                        fail_nxt  = 1'b1;
                    end
                end
                default: state_nxt = ACL_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ACL_IDLE;
            cnt     <= 8'd0;
            miss_id <= 16'h0;
            fail    <= 1'b0;
            for (int i = 0; i < 4; i++) ent[i] <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            miss_id <= miss_id_nxt;
            fail    <= fail_nxt;
            for (int i = 0; i < 4; i++) ent[i] <= ent_nxt[i];
        end
    end

    // Combinational outputs are masked while reset holds the registers.
    assign bus.aclOutLdAck    = load_go && !reset;
    assign bus.aclOutMissReq  = (state == ACL_MREQ);
    assign bus.aclOutMissId   = miss_id;
    assign bus.aclOutMissFail = fail;
    assign bus.regOutHoldMiss = (state != ACL_IDLE) || (miss_det && !reset);
    assign bus.aclEntryA      = ent[0];
    assign bus.aclEntryB      = ent[1];
    assign bus.aclEntryC      = ent[2];
    assign bus.aclEntryD      = ent[3];

endmodule
`default_nettype wire
